mm_result_writer: RTL and testbench

Result-side companion to the matrix-multiply datapath. The datapath reads rows of A and columns of B. This block collects the nine 32-bit R_ij products of a 3x3 multiply through a valid/ready handshake and stores them row-major in an internal C buffer. Once the buffer is full, it transmits the matrix serially on an output stream. A side read port gives random access to C at any time.

---
 rtl/mm_result_writer.sv | 130 +++++++++++++
 tb/tb_mm_result_writer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_result_writer.sv
// Collects N*N results row-major into a C buffer, then streams the full matrix out; side port reads C any time.
// Latency: first out_valid one cycle after the last accept; rd_data one cycle after rd_addr.
// Backpressure: in_ready drops for the whole drain; out_* hold stable while out_ready is low.
module mm_result_writer #(
    parameter int DATA_W = 32,
    parameter int N      = 3,
    parameter int IDX_W  = $clog2(N*N+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  count,
    output logic              done
);

    localparam int NE   = N * N;
    localparam int RC_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [RC_W-1:0]   row, col;
    logic [IDX_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] c_mem [NE];
    logic              accept, xfer, frame_full;

    assign in_ready   = (state != DRAIN);
    assign out_valid  = (state == DRAIN);
    assign done       = (state == DRAIN);
    assign out_last   = out_valid && (rd_ptr == LAST_IDX);
    assign out_data   = out_valid ? c_mem[rd_ptr] : '0;

    // clear wins over both handshakes in the same cycle
    assign accept     = in_valid && in_ready && !clear;
    assign xfer       = out_valid && out_ready && !clear;
    assign frame_full = accept && (count == LAST_IDX);
    assign wr_idx     = IDX_W'(row) * IDX_W'(N) + IDX_W'(col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = frame_full ? DRAIN : FILL;
            FILL:    if (frame_full) state_nxt = DRAIN;
            DRAIN:   if (xfer && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row    <= '0;
            col    <= '0;
            count  <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            row    <= '0;
            col    <= '0;
            count  <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                count <= count + IDX_W'(1);
                if (frame_full) begin
                    row    <= '0;
                    col    <= '0;
                    rd_ptr <= '0;
                end else if (col == RC_W'(N - 1)) begin
                    col <= '0;
                    row <= row + RC_W'(1);
                end else begin
                    col <= col + RC_W'(1);
                end
            end
            if (xfer) begin
                if (out_last) begin
                    row    <= '0;
                    col    <= '0;
                    count  <= '0;
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + IDX_W'(1);
                end
            end
        end
    end

    // C survives clear and end-of-frame; only reset wipes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NE; i++) begin
                c_mem[i] <= '0;
            end
        end else if (accept) begin
            c_mem[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_addr < IDX_W'(NE)) begin
            rd_data <= c_mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_mm_result_writer.sv
// Randomized bench for mm_result_writer: frame-level reference model plus an output-stream scoreboard.
module tb_mm_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        in_ready, out_valid, out_last, done;
    logic [31:0] out_data, rd_data;
    logic [3:0]  count;

    always #5 clk = ~clk;

    mm_result_writer #(.DATA_W(32), .N(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .count    (count),
        .done     (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is nine writes into a flat array, then nine reads out of it.
    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic [31:0] m_c [9];
    int          m_cnt = 0;
    bit          m_drain = 1'b0;
    int          m_ptr = 0;
    logic [31:0] m_rd = '0;
    exp_t        sb_q [$];
    exp_t        mon_e;
    exp_t        push_e;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (m_c[i]) m_c[i] = '0;
            m_cnt   = 0;
            m_drain = 1'b0;
            m_ptr   = 0;
            m_rd    = '0;
            sb_q.delete();
        end else begin
            m_rd = (rd_addr < 4'd9) ? m_c[rd_addr] : 32'h0;
            if (clear) begin
                m_cnt   = 0;
                m_drain = 1'b0;
                m_ptr   = 0;
                sb_q.delete();
            end else if (m_drain) begin
                if (out_ready) begin
                    if (m_ptr == 8) begin
                        m_drain = 1'b0;
                        m_cnt   = 0;
                        m_ptr   = 0;
                    end else begin
                        m_ptr++;
                    end
                end
            end else if (in_valid) begin
                m_c[m_cnt] = in_data;
                m_cnt++;
                if (m_cnt == 9) begin
                    m_drain = 1'b1;
                    m_ptr   = 0;
                    for (int k = 0; k < 9; k++) begin
                        push_e.d = m_c[k];
                        push_e.l = (k == 8);
                        sb_q.push_back(push_e);
                    end
                end
            end
        end
    end

    // Status checker: every cycle out of reset, DUT flags against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, !m_drain});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_drain});
            chk("done", {31'b0, done}, {31'b0, m_drain});
            chk("out_last", {31'b0, out_last}, {31'b0, (m_drain && m_ptr == 8)});
            chk("count", {28'b0, count}, m_cnt);
            chk("rd_data", rd_data, m_rd);
            if (m_drain) chk("out_data", out_data, m_c[m_ptr]);
        end
    end

    // Stream monitor: each transfer must match the next queued element.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !clear) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_pop: unexpected output 0x%0h, expected no transfer", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_data", out_data, mon_e.d);
                chk("sb_last", {31'b0, out_last}, {31'b0, mon_e.l});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while (!in_ready && g < 40) begin
            step();
            g++;
        end
        chk(nm, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_count", {28'b0, count}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        step();
        rst = 1'b1;
        step();

        // back-to-back 1..9 with a free-running consumer
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
        end
        in_valid = 1'b0;
        chk("b2b_in_ready_low", {31'b0, in_ready}, 32'd0);
        wait_idle("b2b_idle");
        rd_addr = 4'd12;
        step();
        chk("rd_oob", rd_data, 32'd0);
        rd_addr = 4'd8;
        step();
        chk("rd_c8", rd_data, 32'd9);

        // gapped producer
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + i;
            step();
            in_valid = 1'b0;
            step();
        end
        wait_idle("gap_idle");

        // consumer stalls for five cycles at element 4
        fill_random();
        for (int g = 0; g < 40 && !(m_drain && m_ptr == 4); g++) step();
        out_ready = 1'b0;
        repeat (5) step();
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_idle("bp_idle");

        // producer keeps pushing 0xDEAD during the drain
        fill_random();
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        for (int g = 0; g < 60 && !in_ready; g++) begin
            out_ready = ($urandom % 2) == 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("dead_count", {28'b0, count}, 32'd0);

        // clear after four accepts, colliding with a fifth
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
        end
        in_data = 32'h55;
        clear   = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", {28'b0, count}, 32'd0);
        chk("clr_in_ready", {31'b0, in_ready}, 32'd1);
        for (int a = 0; a <= 4; a++) begin
            rd_addr = 4'(a);
            step();
        end
        chk("clr_rd4", rd_data, 32'd0);
        fill_random();
        wait_idle("clr_next_idle");

        // asynchronous reset in the middle of a drain
        fill_random();
        for (int g = 0; g < 40 && !(m_drain && m_ptr == 6); g++) step();
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        step();
        rst = 1'b1;
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int a = 0; a < 9; a++) begin
            rd_addr = 4'(a);
            step();
            chk("arst_rd_zero", rd_data, 32'd0);
        end

        // random traffic with occasional aborts
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = $urandom;
            out_ready = ($urandom % 4) != 0;
            rd_addr   = 4'($urandom % 16);
            clear     = ($urandom % 50) == 0;
            step();
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("rand_idle");
        step();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
